// File: rtl/mvb_item_serializer.sv
// mvb_item_serializer
//
// Consumer-side MVB endpoint. Accepts one multi-item MVB word at a time into
// a one-word buffer and emits its valid items one per cycle, lowest index
// first, on a single-item valid/ready stream.
//
// Handshake rule (both sides): a transfer happens on a rising CLK edge where
// SRC_RDY=1 and DST_RDY=1. The source must hold its data and valid bits
// stable until that edge. DST_RDY may depend on the sink's own state only.
//
// Ports:
//   CLK         clock, rising edge
//   RESET_N     asynchronous active-low reset
//   RX_DATA     ITEMS*ITEM_WIDTH input word; item i at [(i+1)*W-1 : i*W]
//   RX_VLD      per-item valid of the input word
//   RX_SRC_RDY  input word present
//   RX_DST_RDY  input word accepted (combinational from TX_DST_RDY only)
//   TX_DATA     current item
//   TX_IDX      source index of the current item within its word
//   TX_LAST     current item is the last pending item of its word
//   TX_SRC_RDY  item present
//   TX_DST_RDY  item consumed
module mvb_item_serializer #(
  parameter  int ITEMS      = 4,
  parameter  int ITEM_WIDTH = 8,
  localparam int IDX_WIDTH  = (ITEMS > 1) ? $clog2(ITEMS) : 1
) (
  input  logic                        CLK,
  input  logic                        RESET_N,
  input  logic [ITEMS*ITEM_WIDTH-1:0] RX_DATA,
  input  logic [ITEMS-1:0]            RX_VLD,
  input  logic                        RX_SRC_RDY,
  output logic                        RX_DST_RDY,
  output logic [ITEM_WIDTH-1:0]       TX_DATA,
  output logic [IDX_WIDTH-1:0]        TX_IDX,
  output logic                        TX_LAST,
  output logic                        TX_SRC_RDY,
  input  logic                        TX_DST_RDY
);

  // Buffer occupancy is fully implied by the pending mask; buf_state is the
  // decoded view of it and is what the TX flags are derived from.
  typedef enum logic [1:0] {
    BUF_EMPTY = 2'd0,
    BUF_ONE   = 2'd1,
    BUF_MULTI = 2'd2
  } buf_state_e;

  logic [ITEMS*ITEM_WIDTH-1:0] buf_data_q, buf_data_d;
  logic [ITEMS-1:0]            pend_q, pend_d;

  buf_state_e                  buf_state;
  logic [IDX_WIDTH-1:0]        sel;
  logic [ITEMS-1:0]            sel_mask;
  logic [ITEM_WIDTH-1:0]       sel_data;
  logic                        tx_hs;
  logic                        rx_hs;

  // Occupancy decode: clearing the lowest set bit leaves zero iff one bit set.
  always_comb begin
    if (pend_q == '0) begin
      buf_state = BUF_EMPTY;
    end else if ((pend_q & (pend_q - ITEMS'(1))) == '0) begin
      buf_state = BUF_ONE;
    end else begin
      buf_state = BUF_MULTI;
    end
  end

  // Priority encoder: scan from the top so the lowest set index wins.
  // With nothing pending the selection rests on item 0, which reset clears,
  // so TX_DATA reads 0 out of reset.
  always_comb begin
    sel      = '0;
    sel_mask = '0;
    sel_data = buf_data_q[ITEM_WIDTH-1:0];
    for (int i = ITEMS - 1; i >= 0; i--) begin
      if (pend_q[i]) begin
        sel         = IDX_WIDTH'(i);
        sel_mask    = '0;
        sel_mask[i] = 1'b1;
        sel_data    = buf_data_q[i*ITEM_WIDTH +: ITEM_WIDTH];
      end
    end
  end

  assign TX_SRC_RDY = (buf_state != BUF_EMPTY);
  assign TX_LAST    = (buf_state == BUF_ONE);
  assign TX_DATA    = sel_data;
  assign TX_IDX     = sel;

  // A new word may land when the buffer is empty or its last item leaves now.
  assign RX_DST_RDY = (buf_state == BUF_EMPTY) || (TX_LAST && TX_DST_RDY);

  assign tx_hs = TX_SRC_RDY && TX_DST_RDY;
  assign rx_hs = RX_SRC_RDY && RX_DST_RDY;

  // A load replaces the whole mask, so it supersedes the clear of the item
  // handed off on the same edge (that item was the last one anyway).
  always_comb begin
    buf_data_d = buf_data_q;
    pend_d     = pend_q;
    if (rx_hs) begin
      buf_data_d = RX_DATA;
      pend_d     = RX_VLD;
    end else if (tx_hs) begin
      pend_d = pend_q & ~sel_mask;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      buf_data_q <= '0;
      pend_q     <= '0;
    end else begin
      buf_data_q <= buf_data_d;
      pend_q     <= pend_d;
    end
  end

endmodule

// File: tb/tb_mvb_item_serializer.sv
module tb_mvb_item_serializer;

  localparam int ITEMS      = 4;
  localparam int ITEM_WIDTH = 8;

  logic                        clk;
  logic                        rst_n;
  logic [ITEMS*ITEM_WIDTH-1:0] rx_data;
  logic [ITEMS-1:0]            rx_vld;
  logic                        rx_src_rdy;
  logic                        rx_dst_rdy;
  logic [ITEM_WIDTH-1:0]       tx_data;
  logic [1:0]                  tx_idx;
  logic                        tx_last;
  logic                        tx_src_rdy;
  logic                        tx_dst_rdy;

  int n_cmp;
  int n_err;

  mvb_item_serializer #(
    .ITEMS      (ITEMS),
    .ITEM_WIDTH (ITEM_WIDTH)
  ) dut (
    .CLK        (clk),
    .RESET_N    (rst_n),
    .RX_DATA    (rx_data),
    .RX_VLD     (rx_vld),
    .RX_SRC_RDY (rx_src_rdy),
    .RX_DST_RDY (rx_dst_rdy),
    .TX_DATA    (tx_data),
    .TX_IDX     (tx_idx),
    .TX_LAST    (tx_last),
    .TX_SRC_RDY (tx_src_rdy),
    .TX_DST_RDY (tx_dst_rdy)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Check the TX side and RX_DST_RDY for the current cycle.
  task automatic tx_expect(input string tag, input logic src, input logic [7:0] data,
                           input logic [1:0] idx, input logic last, input logic rxrdy);
    check_eq({tag, ".src"},   32'(tx_src_rdy), 32'(src));
    check_eq({tag, ".rxrdy"}, 32'(rx_dst_rdy), 32'(rxrdy));
    check_eq({tag, ".last"},  32'(tx_last),    32'(last));
    if (src) begin
      check_eq({tag, ".data"}, 32'(tx_data), 32'(data));
      check_eq({tag, ".idx"},  32'(tx_idx),  32'(idx));
    end
  endtask

  // ---------------- driver ----------------
  // Inputs change on the falling edge; outputs are sampled 1 ns later,
  // well away from the rising edge that transfers.
  task automatic set_in(input logic [31:0] data, input logic [3:0] vld,
                        input logic src, input logic dst);
    @(negedge clk);
    rx_data    = data;
    rx_vld     = vld;
    rx_src_rdy = src;
    tx_dst_rdy = dst;
    #1;
  endtask

  initial begin
    n_cmp      = 0;
    n_err      = 0;
    rst_n      = 1'b0;
    rx_data    = '0;
    rx_vld     = '0;
    rx_src_rdy = 1'b0;
    tx_dst_rdy = 1'b1;

    // ---- reset state ----
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_eq("rst.src",   32'(tx_src_rdy), 32'd0);
    check_eq("rst.rxrdy", 32'(rx_dst_rdy), 32'd1);
    check_eq("rst.data",  32'(tx_data),    32'h00);
    check_eq("rst.idx",   32'(tx_idx),     32'd0);
    check_eq("rst.last",  32'(tx_last),    32'd0);

    // ---- full word, TX always ready ----
    set_in(32'h44332211, 4'b1111, 1'b1, 1'b1);
    tx_expect("full.c0", 1'b0, 8'h00, 2'd0, 1'b0, 1'b1);
    set_in(32'h0, 4'b0000, 1'b0, 1'b1);
    tx_expect("full.c1", 1'b1, 8'h11, 2'd0, 1'b0, 1'b0);
    set_in(32'h0, 4'b0000, 1'b0, 1'b1);
    tx_expect("full.c2", 1'b1, 8'h22, 2'd1, 1'b0, 1'b0);
    set_in(32'h0, 4'b0000, 1'b0, 1'b1);
    tx_expect("full.c3", 1'b1, 8'h33, 2'd2, 1'b0, 1'b0);
    set_in(32'h0, 4'b0000, 1'b0, 1'b1);
    tx_expect("full.c4", 1'b1, 8'h44, 2'd3, 1'b1, 1'b1);
    set_in(32'h0, 4'b0000, 1'b0, 1'b1);
    tx_expect("full.c5", 1'b0, 8'h00, 2'd0, 1'b0, 1'b1);

    // ---- sparse, empty, single-item words ----
    set_in(32'hDDCCBBAA, 4'b1010, 1'b1, 1'b1);
    tx_expect("sparse.c0", 1'b0, 8'h00, 2'd0, 1'b0, 1'b1);
    set_in(32'hEEEEEEEE, 4'b0000, 1'b1, 1'b1);
    tx_expect("sparse.c1", 1'b1, 8'hBB, 2'd1, 1'b0, 1'b0);
    set_in(32'hEEEEEEEE, 4'b0000, 1'b1, 1'b1);
    tx_expect("sparse.c2", 1'b1, 8'hDD, 2'd3, 1'b1, 1'b1);
    set_in(32'h00000077, 4'b0001, 1'b1, 1'b1);
    tx_expect("sparse.c3", 1'b0, 8'h00, 2'd0, 1'b0, 1'b1);
    set_in(32'h0, 4'b0000, 1'b0, 1'b1);
    tx_expect("sparse.c4", 1'b1, 8'h77, 2'd0, 1'b1, 1'b1);
    set_in(32'h0, 4'b0000, 1'b0, 1'b1);
    tx_expect("sparse.c5", 1'b0, 8'h00, 2'd0, 1'b0, 1'b1);

    // ---- back-to-back words, no bubble ----
    set_in(32'h00002211, 4'b0011, 1'b1, 1'b1);
    tx_expect("b2b.c0", 1'b0, 8'h00, 2'd0, 1'b0, 1'b1);
    set_in(32'h00004433, 4'b0011, 1'b1, 1'b1);
    tx_expect("b2b.c1", 1'b1, 8'h11, 2'd0, 1'b0, 1'b0);
    set_in(32'h00004433, 4'b0011, 1'b1, 1'b1);
    tx_expect("b2b.c2", 1'b1, 8'h22, 2'd1, 1'b1, 1'b1);
    set_in(32'h0, 4'b0000, 1'b0, 1'b1);
    tx_expect("b2b.c3", 1'b1, 8'h33, 2'd0, 1'b0, 1'b0);
    set_in(32'h0, 4'b0000, 1'b0, 1'b1);
    tx_expect("b2b.c4", 1'b1, 8'h44, 2'd1, 1'b1, 1'b1);
    set_in(32'h0, 4'b0000, 1'b0, 1'b1);
    tx_expect("b2b.c5", 1'b0, 8'h00, 2'd0, 1'b0, 1'b1);

    // ---- backpressure with a follow-on word waiting ----
    set_in(32'hA4A3A2A1, 4'b1111, 1'b1, 1'b1);
    tx_expect("bp.c0", 1'b0, 8'h00, 2'd0, 1'b0, 1'b1);
    set_in(32'h000000C0, 4'b0001, 1'b1, 1'b1);
    tx_expect("bp.c1", 1'b1, 8'hA1, 2'd0, 1'b0, 1'b0);
    set_in(32'h000000C0, 4'b0001, 1'b1, 1'b0);
    tx_expect("bp.c2", 1'b1, 8'hA2, 2'd1, 1'b0, 1'b0);
    set_in(32'h000000C0, 4'b0001, 1'b1, 1'b0);
    tx_expect("bp.c3", 1'b1, 8'hA2, 2'd1, 1'b0, 1'b0);
    set_in(32'h000000C0, 4'b0001, 1'b1, 1'b1);
    tx_expect("bp.c4", 1'b1, 8'hA2, 2'd1, 1'b0, 1'b0);
    set_in(32'h000000C0, 4'b0001, 1'b1, 1'b1);
    tx_expect("bp.c5", 1'b1, 8'hA3, 2'd2, 1'b0, 1'b0);
    set_in(32'h000000C0, 4'b0001, 1'b1, 1'b0);
    tx_expect("bp.c6", 1'b1, 8'hA4, 2'd3, 1'b1, 1'b0);
    set_in(32'h000000C0, 4'b0001, 1'b1, 1'b1);
    tx_expect("bp.c7", 1'b1, 8'hA4, 2'd3, 1'b1, 1'b1);
    set_in(32'h0, 4'b0000, 1'b0, 1'b1);
    tx_expect("bp.c8", 1'b1, 8'hC0, 2'd0, 1'b1, 1'b1);
    set_in(32'h0, 4'b0000, 1'b0, 1'b1);
    tx_expect("bp.c9", 1'b0, 8'h00, 2'd0, 1'b0, 1'b1);

    // ---- asynchronous reset mid-drain ----
    set_in(32'h54535251, 4'b1111, 1'b1, 1'b1);
    tx_expect("arst.c0", 1'b0, 8'h00, 2'd0, 1'b0, 1'b1);
    set_in(32'h0, 4'b0000, 1'b0, 1'b1);
    tx_expect("arst.c1", 1'b1, 8'h51, 2'd0, 1'b0, 1'b0);
    set_in(32'h0, 4'b0000, 1'b0, 1'b1);
    tx_expect("arst.c2", 1'b1, 8'h52, 2'd1, 1'b0, 1'b0);
    set_in(32'h0, 4'b0000, 1'b0, 1'b1);
    tx_expect("arst.c3", 1'b1, 8'h53, 2'd2, 1'b0, 1'b0);
    #1;
    rst_n = 1'b0;
    #1;
    check_eq("arst.src_now",   32'(tx_src_rdy), 32'd0);
    check_eq("arst.rxrdy_now", 32'(rx_dst_rdy), 32'd1);
    check_eq("arst.data_now",  32'(tx_data),    32'h00);
    #1;
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      set_in(32'h0, 4'b0000, 1'b0, 1'b1);
      tx_expect($sformatf("arst.post%0d", c), 1'b0, 8'h00, 2'd0, 1'b0, 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "time limit");
  end

endmodule

// File: doc/mvb_item_serializer.md
# mvb_item_serializer

Consumer-side MVB endpoint. Accepts multi-item MVB words and emits their valid items one per cycle, in ascending item index order, on a single-item valid/ready stream. Sits at the read end of an MVB pipeline, after MVB_PIPE or any other MVB source. Feeds narrow per-item logic such as table lookups, counters and single-port memories. Internally it holds a one-word buffer with a pending-item mask, so full throughput is sustained when TX never stalls.

## Interface

Parameters:
- ITEMS, 4, items per MVB word; range 1..64
- ITEM_WIDTH, 8, bits per item; must be 1 or more
- IDX_WIDTH, max(1, log2(ITEMS)), width of TX_IDX (derived, not overridable)

Ports:
- CLK  in  1  single clock, rising edge
- RESET_N  in  1  reset, asynchronous, active-low
- RX_DATA  in  ITEMS*ITEM_WIDTH  item i occupies bits [(i+1)*ITEM_WIDTH-1 : i*ITEM_WIDTH]
- RX_VLD  in  ITEMS  per-item valid
- RX_SRC_RDY  in  1  word present
- RX_DST_RDY  out  1  word accepted when RX_SRC_RDY=1 and RX_DST_RDY=1
- TX_DATA  out  ITEM_WIDTH  current item
- TX_IDX  out  IDX_WIDTH  source index of the current item within its word
- TX_LAST  out  1  current item is the last pending item of its word
- TX_SRC_RDY  out  1  item present
- TX_DST_RDY  in  1  item consumed when TX_SRC_RDY=1 and TX_DST_RDY=1

## Operation

- State:
  - buf_data: ITEMS*ITEM_WIDTH register
  - pend: ITEMS-bit pending mask
- Buffer state is implied by pend:
  - EMPTY when pend = 0
  - ONE when popcount(pend) = 1
  - MULTI when popcount(pend) > 1
- Selection:
  - sel = lowest set index in pend (priority encoder).
  - TX_DATA = buf_data item[sel]; TX_IDX = sel.
  - TX_SRC_RDY = (pend != 0).
  - TX_LAST = (pend has exactly one bit set).
- tx_hs = TX_SRC_RDY and TX_DST_RDY.
- RX_DST_RDY = (pend = 0) or (TX_LAST and TX_DST_RDY). It is combinational from TX_DST_RDY; no combinational path from RX inputs.
- On an RX handshake, in the same edge:
  - buf_data <= RX_DATA
  - pend <= RX_VLD
  - This overrides the tx_hs clear.
- On tx_hs without an RX handshake: pend[sel] <= 0.
- RX word with RX_VLD = 0 and RX_SRC_RDY = 1: accepted when RX_DST_RDY = 1. pend stays 0 and nothing is emitted (word is silently dropped).
- RX_VLD bits are honoured only when RX_SRC_RDY = 1. RX_DATA of invalid items is stored but never emitted.
- With RX_SRC_RDY = 0, RX_DATA/RX_VLD are don't-care and the buffer is unchanged except for tx_hs clears.
- Item order is strictly ascending index within a word and word order is preserved. No item is dropped or duplicated.
- TX outputs hold stable while TX_SRC_RDY = 1 and TX_DST_RDY = 0.

## Timing

- Reset (RESET_N = 0, asynchronous):
  - pend = 0 and buf_data = 0.
  - Hence TX_SRC_RDY = 0, TX_DATA = 0, TX_IDX = 0, TX_LAST = 0 and RX_DST_RDY = 1.
  - Reset release is synchronous to CLK by the surrounding reset tree.
- Latency: an item accepted at edge N is visible on TX in cycle N+1 (one register stage).
- Throughput: a word with k valid items drains in k cycles when TX_DST_RDY = 1.
  - The next word is accepted in the cycle its predecessor's last item hands off, so there are no bubbles between words.
  - k = 0 words cost one RX cycle only if the buffer is EMPTY or draining its last item.
- Simultaneous RX handshake and tx_hs of the last item: the old item is consumed, the new word is loaded, and the new first item appears the next cycle.
- TX stall on the last item forces RX_DST_RDY = 0. The RX source must hold its word per MVB rules.
- Reset mid-word: pending items are discarded. No item is emitted after RESET_N asserts.

## Test plan

All scenarios use ITEMS=4, ITEM_WIDTH=8.

- Reset check: reset, then release with idle RX -> TX_SRC_RDY=0, RX_DST_RDY=1, TX_DATA=0x00.
- Full word, TX always ready: RX_DATA=0x44332211, RX_VLD=1111 at edge 0 -> TX emits in cycles 1..4:
  - 0x11/idx0, 0x22/idx1, 0x33/idx2, 0x44/idx3 with TX_LAST=1 on 0x44.
  - RX_DST_RDY=1 again in cycle 4.
- Sparse and empty words: RX_VLD=1010 (data 0xDD_CC_BB_AA), then 0000, then 0001 (0x77) -> TX emits:
  - 0xBB/idx1, then 0xDD/idx3/LAST.
  - Empty word consumed in cycle 3 with no output.
  - 0x77/idx0/LAST in cycle 4.
- Back-to-back words: two words with RX_VLD=0011 each, RX_SRC_RDY held 1 -> 4 consecutive TX items, no bubble, RX accepted on the cycles of LAST handoff.
- Backpressure: TX_DST_RDY toggling 1,0,0,1 during a 1111 word -> TX_DATA/TX_IDX are stable while stalled, RX_DST_RDY=0 until the last item handshake, order intact.
- Async reset mid-drain: after 2 of 4 items, pulse RESET_N low between edges -> TX_SRC_RDY drops immediately, and the remaining 2 items are never emitted.
